// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// pll_lock_supervisor: PLL reset/lock sequencer with timeout-retry and a
// stability window ahead of releasing the core reset.     Rev 1.0
// ============================================================================
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             force_reset,
    output logic             pll_rst,
    output logic             sys_reset,
    output logic             running,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int MAX_A  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C  = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW     = $clog2(MAX_C);

    localparam logic [CW-1:0]    RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t        cur_state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic          sync1;
    logic          locked_s;
    logic          cnt_clear;
    logic          loss_inc;
    logic          timeout_inc;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= locked;
            locked_s <= sync1;
        end
    end

    always_comb begin
        next_state  = cur_state;
        loss_inc    = 1'b0;
        timeout_inc = 1'b0;
        cnt_clear   = 1'b0;
        if (force_reset) begin
            // Re-entering RESET_PLL from itself must still restart the pulse.
            next_state = RESET_PLL;
            cnt_clear  = 1'b1;
        end else begin
            case (cur_state)
                RESET_PLL: if (cnt == RST_LAST) next_state = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (locked_s) begin
                        next_state = STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        next_state  = RESET_PLL;
                        timeout_inc = 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s)                next_state = WAIT_LOCK;
                    else if (cnt == STABLE_LAST)  next_state = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        next_state = RESET_PLL;
                        loss_inc   = 1'b1;
                    end
                end
                default: next_state = RESET_PLL;
            endcase
        end
        if (next_state != cur_state) cnt_clear = 1'b1;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state     <= RESET_PLL;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_reset     <= 1'b1;
            running       <= 1'b0;
            loss_count    <= '0;
            timeout_count <= '0;
        end else begin
            cur_state <= next_state;
            cnt       <= cnt_clear ? '0 : cnt + CW'(1);
            pll_rst   <= (next_state == RESET_PLL);
            sys_reset <= (next_state != RUN);
            running   <= (next_state == RUN);
            if (loss_inc && loss_count != SAT_MAX)
                loss_count <= loss_count + CNT_W'(1);
            if (timeout_inc && timeout_count != SAT_MAX)
                timeout_count <= timeout_count + CNT_W'(1);
        end
    end

    assign state = cur_state;

endmodule
`default_nettype wire
